m_ext_sequencer: RTL and testbench

- Sequences the RV32M unit in the EX stage. Accepts one MUL/DIV-class op at a time from EX over a valid/ready handshake.
- Drives the fixed-latency multiplier by its own cycle counter, and the variable-latency divider by start/done.
- Short-circuits divide-by-zero and signed overflow without starting the divider.
- Returns a 32-bit result as a one-cycle response pulse; EX stalls while req_ready is low.

---
 rtl/m_ext_sequencer_pkg.sv | 27 ++
 rtl/m_ext_sequencer_div_special.sv | 34 +++
 rtl/m_ext_sequencer.sv | 171 +++++++++++++++++
 tb/tb_m_ext_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/m_ext_sequencer_pkg.sv
// Shared types for the RV32M sequencer: funct3 encodings, FSM states and
// the signed-overflow operand pair.
package rv32i_types;

  typedef enum logic [2:0] {
    M_MUL    = 3'b000,
    M_MULH   = 3'b001,
    M_MULHSU = 3'b010,
    M_MULHU  = 3'b011,
    M_DIV    = 3'b100,
    M_DIVU   = 3'b101,
    M_REM    = 3'b110,
    M_REMU   = 3'b111
  } m_funct3_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_WAIT,
    S_DIV_WAIT,
    S_RESP,
    S_ABORT
  } m_seq_state_t;

  localparam logic [31:0] M_OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] M_OVF_DIVISOR  = 32'hFFFF_FFFF;

endpackage

// File: rtl/m_ext_sequencer_div_special.sv
// Combinational detection of divide-by-zero and signed overflow, with the
// architecturally defined quotient/remainder for each case.
module m_ext_div_special
  import rv32i_types::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            signed_op,
  output logic            is_special,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);

  logic div_zero;
  logic overflow;

  always_comb begin
    div_zero   = (b == '0);
    overflow   = signed_op && (a == XLEN'(M_OVF_DIVIDEND)) && (b == XLEN'(M_OVF_DIVISOR));
    is_special = div_zero || overflow;
    quot       = '0;
    rem        = '0;
    if (div_zero) begin
      quot = '1;
      rem  = a;
    end else if (overflow) begin
      quot = a;
      rem  = '0;
    end
  end

endmodule

// File: rtl/m_ext_sequencer.sv
// RV32M sequencer: drives a fixed-latency multiplier and a start/done divider.
// Optional single-entry divider result reuse: define M_EXT_DIV_REUSE_EN.
module m_ext_sequencer
  import rv32i_types::*;
#(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned XLEN        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_rs1,
  input  logic [XLEN-1:0]   req_rs2,
  output logic              req_ready,
  output logic              mul_start,
  output logic [XLEN-1:0]   mul_a,
  output logic [XLEN-1:0]   mul_b,
  output logic              mul_a_signed,
  output logic              mul_b_signed,
  input  logic [2*XLEN-1:0] mul_product,
  output logic              div_start,
  output logic [XLEN-1:0]   div_a,
  output logic [XLEN-1:0]   div_b,
  output logic              div_signed,
  input  logic              div_done,
  input  logic [XLEN-1:0]   div_quot,
  input  logic [XLEN-1:0]   div_rem,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_data
);

  m_seq_state_t    state, state_n;
  logic [3:0]      count;
  m_funct3_t       funct3_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] resp_data_q;
  logic            ready_q;
  logic            div_first;

  logic            accept;
  logic            req_div_signed;
  logic            sp_is_special;
  logic [XLEN-1:0] sp_quot, sp_rem, sp_res;
  logic            reuse_hit;
  logic [XLEN-1:0] reuse_res;

  assign accept         = req_valid && ready_q && !flush;
  assign req_div_signed = req_funct3[2] && !req_funct3[0];
  assign sp_res         = req_funct3[1] ? sp_rem : sp_quot;

  m_ext_div_special #(.XLEN(XLEN)) u_special (
    .a          (req_rs1),
    .b          (req_rs2),
    .signed_op  (req_div_signed),
    .is_special (sp_is_special),
    .quot       (sp_quot),
    .rem        (sp_rem)
  );

`ifdef M_EXT_DIV_REUSE_EN
  logic [XLEN-1:0] reuse_rs1, reuse_rs2, reuse_quot, reuse_rem;
  logic            reuse_signed, reuse_valid;

  assign reuse_hit = reuse_valid && (req_rs1 == reuse_rs1) && (req_rs2 == reuse_rs2)
                     && (req_div_signed == reuse_signed);
  assign reuse_res = req_funct3[1] ? reuse_rem : reuse_quot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reuse_rs1    <= '0;
      reuse_rs2    <= '0;
      reuse_quot   <= '0;
      reuse_rem    <= '0;
      reuse_signed <= 1'b0;
      reuse_valid  <= 1'b0;
    end else if (flush || (state == S_ABORT && div_done)) begin
      reuse_valid <= 1'b0;
    end else if (state == S_DIV_WAIT && state_n == S_RESP) begin
      reuse_rs1    <= div_a;
      reuse_rs2    <= div_b;
      reuse_signed <= div_signed;
      reuse_quot   <= div_quot;
      reuse_rem    <= div_rem;
      reuse_valid  <= 1'b1;
    end
  end
`else
  assign reuse_hit = 1'b0;
  assign reuse_res = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:
        if (accept) begin
          if (!req_funct3[2])                 state_n = S_MUL_WAIT;
          else if (sp_is_special || reuse_hit) state_n = S_RESP;
          else                                 state_n = S_DIV_WAIT;
        end
      S_MUL_WAIT:
        if (flush)                                 state_n = S_IDLE;
        else if (count == 4'(MUL_LATENCY - 1))     state_n = S_RESP;
      // A done pulse in the same cycle as the start pulse belongs to a prior op.
      S_DIV_WAIT:
        if (flush)                          state_n = S_ABORT;
        else if (div_done && !div_first)    state_n = S_RESP;
      S_RESP:  state_n = S_IDLE;
      S_ABORT: if (div_done) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign req_ready  = ready_q;
  assign mul_start  = (state == S_MUL_WAIT) && (count == '0);
  assign div_start  = (state == S_DIV_WAIT) && div_first;
  assign resp_valid = (state == S_RESP) && !flush;
  // resp_data only advances on a delivered response; a flushed RESP keeps the old value.
  assign resp_data  = resp_valid ? result_q : resp_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count        <= '0;
      funct3_q     <= M_MUL;
      result_q     <= '0;
      resp_data_q  <= '0;
      ready_q      <= 1'b0;
      div_first    <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      mul_a_signed <= 1'b0;
      mul_b_signed <= 1'b0;
      div_a        <= '0;
      div_b        <= '0;
      div_signed   <= 1'b0;
    end else begin
      ready_q   <= (state_n == S_IDLE);
      count     <= (state == S_MUL_WAIT && state_n == S_MUL_WAIT) ? count + 4'd1 : '0;
      div_first <= (state == S_IDLE && state_n == S_DIV_WAIT);

      if (state == S_IDLE && accept) begin
        funct3_q     <= m_funct3_t'(req_funct3);
        mul_a        <= req_rs1;
        mul_b        <= req_rs2;
        mul_a_signed <= (req_funct3 == M_MULH) || (req_funct3 == M_MULHSU);
        mul_b_signed <= (req_funct3 == M_MULH);
        div_a        <= req_rs1;
        div_b        <= req_rs2;
        div_signed   <= req_div_signed;
      end

      if (state == S_IDLE && state_n == S_RESP)
        result_q <= sp_is_special ? sp_res : reuse_res;
      else if (state == S_MUL_WAIT && state_n == S_RESP)
        result_q <= (funct3_q == M_MUL) ? mul_product[XLEN-1:0] : mul_product[2*XLEN-1:XLEN];
      else if (state == S_DIV_WAIT && state_n == S_RESP)
        result_q <= funct3_q[1] ? div_rem : div_quot;

      if (state == S_RESP && !flush)
        resp_data_q <= result_q;
    end
  end

endmodule

// File: tb/tb_m_ext_sequencer.sv
// Scoreboard bench for m_ext_sequencer with behavioural multiplier and
// 10-cycle divider models; honours M_EXT_DIV_REUSE_EN when defined.
module tb_m_ext_sequencer;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1, req_rs2;
  logic        req_ready;
  logic        mul_start;
  logic [31:0] mul_a, mul_b;
  logic        mul_a_signed, mul_b_signed;
  logic [63:0] mul_product;
  logic        div_start;
  logic [31:0] div_a, div_b;
  logic        div_signed;
  logic        div_done;
  logic [31:0] div_quot, div_rem;
  logic        resp_valid;
  logic [31:0] resp_data;

  int checks = 0;
  int errors = 0;
  int dstarts = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  m_ext_sequencer #(.MUL_LATENCY(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_funct3(req_funct3), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_ready(req_ready),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_a_signed(mul_a_signed), .mul_b_signed(mul_b_signed), .mul_product(mul_product),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_signed(div_signed),
    .div_done(div_done), .div_quot(div_quot), .div_rem(div_rem),
    .resp_valid(resp_valid), .resp_data(resp_data)
  );

  // Multiplier model: product of the held operands, sign-extended per flag.
  logic signed [65:0] pa, pb, pp;
  always_comb begin
    pa = {{34{mul_a_signed & mul_a[31]}}, mul_a};
    pb = {{34{mul_b_signed & mul_b[31]}}, mul_b};
    pp = pa * pb;
    mul_product = pp[63:0];
  end

  // Divider model: done pulses 10 cycles after the sampled start.
  int   dcnt;
  logic dbusy;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_done <= 1'b0; dbusy <= 1'b0; dcnt <= 0; div_quot <= '0; div_rem <= '0;
    end else begin
      div_done <= 1'b0;
      if (div_start) begin
        dbusy <= 1'b1; dcnt <= 10;
      end else if (dbusy) begin
        if (dcnt == 1) begin
          dbusy <= 1'b0; div_done <= 1'b1;
          if (div_signed) begin
            div_quot <= $signed(div_a) / $signed(div_b);
            div_rem  <= $signed(div_a) % $signed(div_b);
          end else begin
            div_quot <= div_a / div_b;
            div_rem  <= div_a % div_b;
          end
        end else dcnt <= dcnt - 1;
      end
    end
  end

  always @(posedge clk) if (rst && div_start) dstarts++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every delivered response must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got %h expected no response", resp_data);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        check("resp_data", {32'h0, resp_data}, {32'h0, e});
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1 within 200 cycles");
    end
  endtask

  // Returns #1 into the first cycle after the accepting edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit want);
    wait_ready();
    req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b;
    if (want) sb.push_back(exp);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1);
  end

  initial begin
    int base;
    bit bad, seen;
    rst = 1'b0; flush = 1'b0; req_valid = 1'b0; req_funct3 = '0; req_rs1 = '0; req_rs2 = '0;
    #12;
    check("reset_ctrl", {57'h0, req_ready, mul_start, div_start, resp_valid,
                         mul_a_signed, mul_b_signed, div_signed}, 64'h0);
    check("reset_data", {32'h0, resp_data | mul_a | mul_b | div_a | div_b}, 64'h0);
    @(negedge clk) rst = 1'b1;

    // MULHU timing: start at T+1, response only at T+5
    issue(M_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
    check("mulhu_start_t1", {63'h0, mul_start}, 64'h1);
    for (int k = 2; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 2) check("mulhu_start_pulse", {63'h0, mul_start}, 64'h0);
      check("mulhu_resp_timing", {63'h0, resp_valid}, {63'h0, (k == 5)});
    end
    issue(M_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1);
    issue(M_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    issue(M_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);

    // DIV -7/2 with req_ready low until the response
    issue(M_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 1);
    bad = 1'b0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) begin seen = 1'b1; break; end
      if (req_ready) bad = 1'b1;
    end
    check("div_ready_low", {63'h0, bad}, 64'h0);
    check("div_resp_seen", {63'h0, seen}, 64'h1);
    issue(M_REM, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 1);

    // Short-circuit cases: response at T+1, divider untouched
    wait_ready();
    base = dstarts;
    issue(M_DIVU, 32'h5, 32'h0, 32'hFFFF_FFFF, 1);
    check("divzero_t1", {63'h0, resp_valid}, 64'h1);
    issue(M_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    check("ovf_rem_t1", {63'h0, resp_valid}, 64'h1);
    issue(M_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    issue(M_REMU, 32'h0000_1234, 32'h0, 32'h0000_1234, 1);
    wait_ready();
    check("special_no_div_start", dstarts - base, 64'h0);
    issue(M_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

    // Flush two cycles into DIV_WAIT
    issue(M_DIVU, 32'd100, 32'd3, 32'h0, 0);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    bad = 1'b0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (div_done) begin seen = 1'b1; break; end
      if (req_ready) bad = 1'b1;
    end
    check("abort_ready_low", {63'h0, bad}, 64'h0);
    check("abort_done_seen", {63'h0, seen}, 64'h1);
    @(posedge clk); #1;
    check("abort_ready_after", {63'h0, req_ready}, 64'h1);
    issue(M_MUL, 32'd3, 32'd4, 32'd12, 1);

    // DIV then REM on the same operands
    issue(M_DIV, 32'd100, 32'd7, 32'd14, 1);
    wait_ready();
    base = dstarts;
    issue(M_REM, 32'd100, 32'd7, 32'd2, 1);
`ifdef M_EXT_DIV_REUSE_EN
    check("reuse_hit_t1", {63'h0, resp_valid}, 64'h1);
    wait_ready();
    check("reuse_no_div_start", dstarts - base, 64'h0);
`else
    check("noreuse_not_t1", {63'h0, resp_valid}, 64'h0);
    wait_ready();
    check("noreuse_div_start", dstarts - base, 64'h1);
`endif

    // Flush in IDLE with req_valid: nothing accepted
    req_valid = 1'b1; req_funct3 = M_MUL; req_rs1 = 32'd5; req_rs2 = 32'd5; flush = 1'b1;
    @(posedge clk); #1;
    check("idle_flush_no_accept", {62'h0, mul_start, req_ready}, 64'h1);
    req_valid = 1'b0; flush = 1'b0;
    wait_ready();
    base = dstarts;
    issue(M_REM, 32'd100, 32'd7, 32'd2, 1);
    wait_ready();
    check("after_flush_div_start", dstarts - base, 64'h1);

    // Asynchronous reset in the middle of MUL_WAIT
    issue(M_MUL, 32'd7, 32'd9, 32'h0, 0);
    @(posedge clk); @(posedge clk); #3 rst = 1'b0;
    #1;
    check("midop_rst_ctrl", {57'h0, req_ready, mul_start, div_start, resp_valid,
                             mul_a_signed, mul_b_signed, div_signed}, 64'h0);
    check("midop_rst_data", {32'h0, resp_data | mul_a | mul_b | div_a | div_b}, 64'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("rst_release_ready", {63'h0, req_ready}, 64'h1);
    issue(M_MUL, 32'd6, 32'd7, 32'd42, 1);

    wait_ready();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
